// File: rtl/branch_resolver.sv
// branch_resolver: conditional-branch resolution unit with a flag register,
// a three-state request/evaluate/flush sequencer and a table of 2-bit
// saturating branch predictors.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   flag_we, carry_in,
//   zero_in, sign_in            flag register load
//   br_valid / br_ready         branch request handshake
//   branch                      3-bit condition code
//   pc, offset, reg_target      branch PC, signed PC-relative offset, register target
//   pred_taken                  front-end prediction for this branch
//   lookup_pc / lookup_taken    combinational predictor read
//   res_valid, jump,
//   mispredict, target          one-cycle resolution result
//   link_we, link_addr          return-address write (condition code 010)
//   flush                       pipeline flush pulse after a mispredict
//   flags_q                     flag register {carry, zero, sign}
module branch_resolver #(
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic              carry_in,
  input  logic              zero_in,
  input  logic              sign_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        branch,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              lookup_taken,
  output logic              res_valid,
  output logic              jump,
  output logic              mispredict,
  output logic [ADDR_W-1:0] target,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              flush,
  output logic [2:0]        flags_q
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EVAL  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  flush_cnt;

  // Branch captured at acceptance; flags include the same-cycle bypass.
  logic [2:0]        cap_code;
  logic [ADDR_W-1:0] cap_pc;
  logic [ADDR_W-1:0] cap_off;
  logic [ADDR_W-1:0] cap_rt;
  logic              cap_pred;
  logic [2:0]        cap_flags;

  logic [1:0]        ctr [DEPTH];

  logic              eval_taken;
  logic              eval_mis;
  logic [ADDR_W-1:0] eval_target;
  logic [IDX_W-1:0]  upd_idx;
  logic [1:0]        upd_cur;

  // Upper address bits do not participate in predictor indexing.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[ADDR_W-1:IDX_W], cap_pc[ADDR_W-1:IDX_W]};

  assign br_ready     = (state == ST_IDLE);
  assign flush        = (state == ST_FLUSH);
  assign lookup_taken = ctr[lookup_pc[IDX_W-1:0]][1];
  assign upd_idx      = cap_pc[IDX_W-1:0];
  assign upd_cur      = ctr[upd_idx];

  always_comb begin
    eval_taken = 1'b0;
    case (cap_code)
      3'b000: eval_taken = 1'b0;
      3'b001: eval_taken = 1'b1;
      3'b010: eval_taken = 1'b1;
      3'b011: eval_taken = cap_flags[0] && !cap_flags[1];
      3'b100: eval_taken = cap_flags[1];
      3'b101: eval_taken = !cap_flags[1];
      3'b110: eval_taken = cap_flags[2];
      3'b111: eval_taken = !cap_flags[2];
      default: eval_taken = 1'b0;
    endcase
  end

  always_comb begin
    eval_target = cap_pc + cap_off;
    if (cap_code == 3'b001)
      eval_target = cap_rt;
    else if (cap_code == 3'b000)
      eval_target = cap_pc + ADDR_W'(1);
  end

  assign eval_mis = (eval_taken != cap_pred);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      flags_q    <= '0;
      cap_code   <= '0;
      cap_pc     <= '0;
      cap_off    <= '0;
      cap_rt     <= '0;
      cap_pred   <= 1'b0;
      cap_flags  <= '0;
      res_valid  <= 1'b0;
      jump       <= 1'b0;
      mispredict <= 1'b0;
      link_we    <= 1'b0;
      target     <= '0;
      link_addr  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        ctr[i] <= 2'b01;
    end else begin
      res_valid  <= 1'b0;
      jump       <= 1'b0;
      mispredict <= 1'b0;
      link_we    <= 1'b0;

      if (flag_we)
        flags_q <= {carry_in, zero_in, sign_in};

      case (state)
        ST_IDLE: begin
          if (br_valid) begin
            cap_code  <= branch;
            cap_pc    <= pc;
            cap_off   <= offset;
            cap_rt    <= reg_target;
            cap_pred  <= pred_taken;
            cap_flags <= flag_we ? {carry_in, zero_in, sign_in} : flags_q;
            state     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          res_valid  <= 1'b1;
          jump       <= eval_taken;
          mispredict <= eval_mis;
          target     <= eval_target;
          if (cap_code == 3'b010) begin
            link_we   <= 1'b1;
            link_addr <= cap_pc + ADDR_W'(1);
          end
          if (cap_code >= 3'b011) begin
            if (eval_taken)
              ctr[upd_idx] <= (upd_cur == 2'b11) ? upd_cur : upd_cur + 2'b01;
            else
              ctr[upd_idx] <= (upd_cur == 2'b00) ? upd_cur : upd_cur - 2'b01;
          end
          if (eval_mis) begin
            state     <= ST_FLUSH;
            flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0)
            state <= ST_IDLE;
          else
            flush_cnt <= flush_cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int FC     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flag_we, carry_in, zero_in, sign_in;
  logic              br_valid, br_ready;
  logic [2:0]        branch;
  logic [ADDR_W-1:0] pc, offset, reg_target, lookup_pc;
  logic              pred_taken, lookup_taken;
  logic              res_valid, jump, mispredict, link_we, flush;
  logic [ADDR_W-1:0] target, link_addr;
  logic [2:0]        flags_q;

  branch_resolver #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .carry_in(carry_in),
    .zero_in(zero_in), .sign_in(sign_in), .br_valid(br_valid),
    .br_ready(br_ready), .branch(branch), .pc(pc), .offset(offset),
    .reg_target(reg_target), .pred_taken(pred_taken), .lookup_pc(lookup_pc),
    .lookup_taken(lookup_taken), .res_valid(res_valid), .jump(jump),
    .mispredict(mispredict), .target(target), .link_we(link_we),
    .link_addr(link_addr), .flush(flush), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  pre;     // flags loaded the cycle before the request
    logic        byp;     // flag_we in the accept cycle
    logic [2:0]  bflags;  // flags presented in the accept cycle
    logic [2:0]  code;
    logic [31:0] pc, off, rt;
    logic        pred;
    logic        ej;
    logic [31:0] etgt;
    logic        emis;
    logic        elink;
  } vec_t;

  typedef struct {
    logic        ej;
    logic [31:0] etgt;
    logic        emis;
    logic        elink;
    logic [31:0] eladdr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model[DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] pre, input logic byp, input logic [2:0] bf,
                              input logic [2:0] code, input logic [31:0] p, input logic [31:0] o,
                              input logic [31:0] r, input logic pr, input logic ej,
                              input logic [31:0] t, input logic em, input logic el);
    vec_t v;
    v.pre = pre; v.byp = byp; v.bflags = bf; v.code = code; v.pc = p; v.off = o;
    v.rt = r; v.pred = pr; v.ej = ej; v.etgt = t; v.emis = em; v.elink = el;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 1;
  endfunction

  // Scoreboard: every result cycle pops one expectation; outside result
  // cycles the pulse outputs must stay low.
  always @(negedge clk) begin
    if (res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 32'(res_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("jump", 32'(jump), 32'(e.ej));
        chk("target", target, e.etgt);
        chk("mispredict", 32'(mispredict), 32'(e.emis));
        chk("link_we", 32'(link_we), 32'(e.elink));
        if (e.elink) chk("link_addr", link_addr, e.eladdr);
      end
    end else begin
      chk("idle_pulses", {29'd0, jump, mispredict, link_we}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_branch(input vec_t v);
    exp_t e;
    flag_we = v.byp; {carry_in, zero_in, sign_in} = v.bflags;
    br_valid = 1'b1; branch = v.code; pc = v.pc; offset = v.off;
    reg_target = v.rt; pred_taken = v.pred;
    e.ej = v.ej; e.etgt = v.etgt; e.emis = v.emis; e.elink = v.elink;
    e.eladdr = v.pc + 32'd1;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    int idx;
    int pre_ctr;
    idx = int'(v.pc[3:0]);
    flag_we = 1'b1; {carry_in, zero_in, sign_in} = v.pre;
    step();
    drive_branch(v);
    @(negedge clk);
    chk("ready_idle", 32'(br_ready), 32'd1);
    step();                                   // EVAL cycle
    br_valid = 1'b0; flag_we = 1'b0;
    lookup_pc = v.pc;
    chk("flags_q", 32'(flags_q), 32'(v.byp ? v.bflags : v.pre));
    @(negedge clk);
    chk("eval_no_result", 32'(res_valid), 32'd0);
    chk("eval_not_ready", 32'(br_ready), 32'd0);
    chk("lookup_pre_update", 32'(lookup_taken), 32'(model[idx] >= 2));
    pre_ctr = model[idx];
    if (v.code >= 3'b011)
      model[idx] = v.ej ? ((pre_ctr == 3) ? 3 : pre_ctr + 1)
                        : ((pre_ctr == 0) ? 0 : pre_ctr - 1);
    step();                                   // result cycle
    @(negedge clk);
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("flush_first", 32'(flush), 32'(v.emis));
    chk("ready_result", 32'(br_ready), 32'(!v.emis));
    if (v.emis) begin
      for (int k = 1; k < FC; k++) begin
        step(); @(negedge clk);
        chk("flush_hold", 32'(flush), 32'd1);
        chk("flush_not_ready", 32'(br_ready), 32'd0);
      end
      step(); @(negedge clk);
      chk("flush_end", 32'(flush), 32'd0);
      chk("ready_after_flush", 32'(br_ready), 32'd1);
    end
    chk("lookup_post_update", 32'(lookup_taken), 32'(model[idx] >= 2));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    tbl[0]  = mk(3'b010, 0, 3'b000, 3'b100, 32'h10, 32'h4, 32'h0, 0, 1, 32'h14, 1, 0);
    tbl[1]  = mk(3'b010, 1, 3'b000, 3'b101, 32'h20, 32'h8, 32'h0, 1, 1, 32'h28, 0, 0);
    tbl[2]  = mk(3'b000, 0, 3'b000, 3'b010, 32'hFFFFFFFF, 32'h81, 32'h80, 1, 1, 32'h80, 0, 1);
    tbl[3]  = mk(3'b000, 0, 3'b000, 3'b000, 32'h100, 32'h50, 32'h0, 1, 0, 32'h101, 1, 0);
    tbl[4]  = mk(3'b000, 0, 3'b000, 3'b000, 32'h200, 32'h9, 32'h0, 0, 0, 32'h201, 0, 0);
    tbl[5]  = mk(3'b000, 0, 3'b000, 3'b001, 32'h300, 32'h4, 32'h1234, 0, 1, 32'h1234, 1, 0);
    tbl[6]  = mk(3'b001, 0, 3'b000, 3'b011, 32'h7, 32'hFFFFFFFE, 32'h0, 1, 1, 32'h5, 0, 0);
    tbl[7]  = mk(3'b011, 0, 3'b000, 3'b011, 32'h8, 32'h10, 32'h0, 0, 0, 32'h18, 0, 0);
    tbl[8]  = mk(3'b100, 0, 3'b000, 3'b110, 32'h33, 32'h1, 32'h0, 0, 1, 32'h34, 1, 0);
    tbl[9]  = mk(3'b100, 0, 3'b000, 3'b111, 32'h44, 32'h2, 32'h0, 1, 0, 32'h46, 1, 0);
    tbl[10] = mk(3'b000, 0, 3'b000, 3'b100, 32'h60, 32'h10, 32'h0, 0, 0, 32'h70, 0, 0);
    tbl[11] = mk(3'b010, 0, 3'b000, 3'b101, 32'h70, 32'hFFFFFFF0, 32'h0, 0, 0, 32'h60, 0, 0);

    rst = 1'b1; flag_we = 1'b1; {carry_in, zero_in, sign_in} = 3'b111;
    br_valid = 1'b1; branch = 3'b001; pc = '0; offset = '0; reg_target = '0;
    pred_taken = 1'b0; lookup_pc = '0;
    model_reset();
    step(); step();
    rst = 1'b0; flag_we = 1'b0; br_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(br_ready), 32'd1);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_target", target, 32'd0);
    chk("rst_link_addr", link_addr, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      lookup_pc = 32'(i); #1;
      chk("rst_counter", 32'(lookup_taken), 32'd0);
    end

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Saturation at pc index 3 from reset; index 4 untouched.
    do_reset();
    v = mk(3'b100, 0, 3'b000, 3'b110, 32'h3, 32'h4, 32'h0, 1, 1, 32'h7, 0, 0);
    for (int i = 0; i < 4; i++) run_vec(v);
    lookup_pc = 32'h4; #1;
    chk("idx4_untouched", 32'(lookup_taken), 32'd0);
    v = mk(3'b000, 0, 3'b000, 3'b110, 32'h3, 32'h4, 32'h0, 0, 0, 32'h7, 0, 0);
    run_vec(v);                                // 11 -> 10
    lookup_pc = 32'h3; #1;
    chk("sat_after_one_dec", 32'(lookup_taken), 32'd1);
    run_vec(v);                                // 10 -> 01
    lookup_pc = 32'h3; #1;
    chk("sat_after_two_dec", 32'(lookup_taken), 32'd0);

    // Reset during the first flush cycle.
    do_reset();
    flag_we = 1'b1; {carry_in, zero_in, sign_in} = 3'b100;
    step();
    drive_branch(mk(3'b100, 0, 3'b000, 3'b110, 32'h3, 32'h4, 32'h0, 0, 1, 32'h7, 1, 0));
    step(); br_valid = 1'b0; flag_we = 1'b0;
    step();                                    // result / first flush cycle
    rst = 1'b1; flag_we = 1'b1; {carry_in, zero_in, sign_in} = 3'b111; br_valid = 1'b1;
    @(negedge clk);
    chk("abort_flush_first", 32'(flush), 32'd1);
    step();
    rst = 1'b0; flag_we = 1'b0; br_valid = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_flush_low", 32'(flush), 32'd0);
    chk("abort_ready", 32'(br_ready), 32'd1);
    chk("abort_flags", 32'(flags_q), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      lookup_pc = 32'(i); #1;
      chk("abort_counter", 32'(lookup_taken), 32'd0);
    end
    step(); @(negedge clk);
    chk("abort_still_idle", 32'(flush), 32'd0);

    // Reset during EVAL: no result, no predictor update.
    flag_we = 1'b1; {carry_in, zero_in, sign_in} = 3'b100;
    step();
    flag_we = 1'b0; br_valid = 1'b1; branch = 3'b110; pc = 32'h5; offset = 32'h1;
    pred_taken = 1'b1;
    step();                                    // EVAL
    br_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("eval_abort_no_result", 32'(res_valid), 32'd0);
    chk("eval_abort_ready", 32'(br_ready), 32'd1);
    lookup_pc = 32'h5; #1;
    chk("eval_abort_no_update", 32'(lookup_taken), 32'd0);
    step(); step();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
